// File: rtl/pong_engine.sv
// Pong game-state engine: once per game tick moves paddles, advances the ball, scores,
// then requests one frame render from the mapper over a start/busy handshake.
module pong_engine #(
    parameter int MAP_WIDTH     = 80,
    parameter int MAP_HEIGHT    = 24,
    parameter int PADDLE_WIDTH  = 2,
    parameter int PADDLE_HEIGHT = 10,
    parameter int PADDLE_0_X    = 2,
    parameter int PADDLE_1_X    = 76,
    parameter int TICK_DIV      = 5000000,
    parameter int WIN_SCORE     = 9
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       up_0,
    input  logic       down_0,
    input  logic       up_1,
    input  logic       down_1,
    output logic [7:0] ball_x,
    output logic [7:0] ball_y,
    output logic [7:0] paddle_0_x,
    output logic [7:0] paddle_0_y,
    output logic [7:0] paddle_1_x,
    output logic [7:0] paddle_1_y,
    output logic [3:0] score_0,
    output logic [3:0] score_1,
    output logic       start,
    input  logic       busy,
    output logic       game_over
);
    localparam int         CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] PAD_MAX = 8'(MAP_HEIGHT - 1 - PADDLE_HEIGHT);
    localparam logic [7:0] PAD_Y0  = 8'((MAP_HEIGHT - PADDLE_HEIGHT) / 2);
    localparam logic [7:0] BALL_X0 = 8'(MAP_WIDTH / 2);
    localparam logic [7:0] BALL_Y0 = 8'(MAP_HEIGHT / 2);

    typedef enum logic [2:0] {IDLE, PADDLE, BALL, REQ, WAIT_HI, WAIT_LO} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [7:0]       bx_q, bx_d, by_q, by_d;
    logic             dxn_q, dxn_d, dyn_q, dyn_d;  // 1 = moving toward lower coordinate
    logic [7:0]       p0y_q, p0y_d, p1y_q, p1y_d;
    logic [3:0]       s0_q, s0_d, s1_q, s1_d;
    logic             go_q, go_d;
    logic             wrap, pend_clr, ndxn, ndyn;

    function automatic logic [7:0] move_paddle(input logic [7:0] y, input logic up,
                                               input logic dn);
        move_paddle = y;
        if (up && !dn && y > 8'd1)
            move_paddle = y - 8'd1;
        else if (dn && !up && y < PAD_MAX)
            move_paddle = y + 8'd1;
    endfunction

    function automatic logic on_paddle(input logic [7:0] y, input logic [7:0] top);
        return (y >= top) && (y <= top + 8'(PADDLE_HEIGHT - 1));
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= 4'(WIN_SCORE)) ? s : s + 4'd1;
    endfunction

    always_comb begin
        state_d  = state_q;
        bx_d     = bx_q;
        by_d     = by_q;
        dxn_d    = dxn_q;
        dyn_d    = dyn_q;
        p0y_d    = p0y_q;
        p1y_d    = p1y_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        pend_clr = 1'b0;
        start    = 1'b0;
        ndxn     = dxn_q;
        ndyn     = dyn_q;

        wrap  = (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_clr = 1'b1;
                    state_d  = PADDLE;
                end
            end
            PADDLE: begin
                p0y_d   = move_paddle(p0y_q, up_0, down_0);
                p1y_d   = move_paddle(p1y_q, up_1, down_1);
                state_d = BALL;
            end
            BALL: begin
                state_d = REQ;
                if (!go_q) begin
                    // Wall and paddle flips are independent, so a corner hit flips both.
                    if (dyn_q && by_q == 8'd1)
                        ndyn = 1'b0;
                    else if (!dyn_q && by_q == 8'(MAP_HEIGHT - 2))
                        ndyn = 1'b1;
                    if (dxn_q && bx_q == 8'(PADDLE_0_X + PADDLE_WIDTH) && on_paddle(by_q, p0y_q))
                        ndxn = 1'b0;
                    else if (!dxn_q && bx_q == 8'(PADDLE_1_X - 1) && on_paddle(by_q, p1y_q))
                        ndxn = 1'b1;

                    if (dxn_q && bx_q == 8'd1) begin
                        s1_d  = sat_inc(s1_q);
                        bx_d  = BALL_X0;
                        by_d  = BALL_Y0;
                        dxn_d = 1'b1;
                        dyn_d = 1'b0;
                    end else if (!dxn_q && bx_q == 8'(MAP_WIDTH - 2)) begin
                        s0_d  = sat_inc(s0_q);
                        bx_d  = BALL_X0;
                        by_d  = BALL_Y0;
                        dxn_d = 1'b0;
                        dyn_d = 1'b0;
                    end else begin
                        bx_d  = ndxn ? bx_q - 8'd1 : bx_q + 8'd1;
                        by_d  = ndyn ? by_q - 8'd1 : by_q + 8'd1;
                        dxn_d = ndxn;
                        dyn_d = ndyn;
                    end
                end
            end
            REQ: begin
                if (!busy) begin
                    start   = 1'b1;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: if (busy) state_d = WAIT_LO;
            WAIT_LO: if (!busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A wrap while a tick is already pending merges into it.
        pend_d = wrap ? 1'b1 : (pend_clr ? 1'b0 : pend_q);
        go_d   = go_q || (s0_d == 4'(WIN_SCORE)) || (s1_d == 4'(WIN_SCORE));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            bx_q    <= BALL_X0;
            by_q    <= BALL_Y0;
            dxn_q   <= 1'b0;
            dyn_q   <= 1'b0;
            p0y_q   <= PAD_Y0;
            p1y_q   <= PAD_Y0;
            s0_q    <= 4'd0;
            s1_q    <= 4'd0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dxn_q   <= dxn_d;
            dyn_q   <= dyn_d;
            p0y_q   <= p0y_d;
            p1y_q   <= p1y_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            go_q    <= go_d;
        end
    end

    assign ball_x     = bx_q;
    assign ball_y     = by_q;
    assign paddle_0_x = 8'(PADDLE_0_X);
    assign paddle_0_y = p0y_q;
    assign paddle_1_x = 8'(PADDLE_1_X);
    assign paddle_1_y = p1y_q;
    assign score_0    = s0_q;
    assign score_1    = s1_q;
    assign game_over  = go_q;
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine (TICK_DIV=4); a mapper model holds busy for 20 cycles
// per frame and frame-by-frame expectations follow hand-traced ball trajectories.
module tb_pong_engine;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       up_0 = 1'b0, down_0 = 1'b0, up_1 = 1'b0, down_1 = 1'b0;
    logic       busy = 1'b0;
    logic [7:0] ball_x, ball_y, paddle_0_x, paddle_0_y, paddle_1_x, paddle_1_y;
    logic [3:0] score_0, score_1;
    logic       start, game_over;

    int         n_cmp = 0;
    int         n_err = 0;
    int         t = 0;
    int         lat = 0;
    int         stray = 0;
    int         moved = 0;
    logic [7:0] bx, by, p0, p1;
    logic [3:0] s0, s1;
    logic       go;

    always #5 clock = ~clock;

    pong_engine #(.TICK_DIV(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .up_0(up_0), .down_0(down_0), .up_1(up_1), .down_1(down_1),
        .ball_x(ball_x), .ball_y(ball_y),
        .paddle_0_x(paddle_0_x), .paddle_0_y(paddle_0_y),
        .paddle_1_x(paddle_1_x), .paddle_1_y(paddle_1_y),
        .score_0(score_0), .score_1(score_1),
        .start(start), .busy(busy), .game_over(game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full frame: wait for start, sample outputs, then play the mapper's busy window.
    task automatic do_frame(input int extra, output int latency);
        bit got = 1'b0;
        int c = 0;
        while (!got && c < 300) begin
            @(posedge clock); #1;
            c++;
            if (start) got = 1'b1;
        end
        latency = c;
        chk("start_seen", 32'(got), 1);
        bx = ball_x; by = ball_y; p0 = paddle_0_y; p1 = paddle_1_y;
        s0 = score_0; s1 = score_1; go = game_over;
        @(posedge clock); #1;
        if (start) stray++;
        busy = 1'b1;
        repeat (20 + extra) begin
            @(posedge clock); #1;
            if (start) stray++;
            if (ball_x !== bx || ball_y !== by || paddle_0_y !== p0 || paddle_1_y !== p1 ||
                score_0 !== s0 || score_1 !== s1)
                moved++;
        end
        busy = 1'b0;
        t++;
    endtask

    task automatic run_until(input int n);
        int l;
        while (t < n) do_frame(0, l);
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(bx), x);
        chk({tag, "_y"}, 32'(by), y);
    endtask

    initial begin
        bit got;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ball_x", 32'(ball_x), 40);
        chk("rst_ball_y", 32'(ball_y), 12);
        chk("rst_p0y", 32'(paddle_0_y), 7);
        chk("rst_p1y", 32'(paddle_1_y), 7);
        chk("p0x", 32'(paddle_0_x), 2);
        chk("p1x", 32'(paddle_1_x), 76);
        chk("rst_s0", 32'(score_0), 0);
        chk("rst_s1", 32'(score_1), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_go", 32'(game_over), 0);

        // First frame: wrap on 4th edge, start visible after the 7th.
        reset_n = 1'b1;
        do_frame(0, lat);
        chk("first_latency", lat, 7);
        chk_ball("f1", 41, 13);
        chk("f1_p0y", 32'(p0), 7);
        chk("f1_p1y", 32'(p1), 7);
        chk("f1_s0", 32'(s0), 0);
        chk("f1_s1", 32'(s1), 0);
        chk("f1_go", 32'(go), 0);

        // Left paddle climbs to the top limit and stays.
        up_0 = 1'b1;
        for (int f = 2; f <= 11; f++) begin
            run_until(f);
            chk("p0y_up", 32'(p0), (f <= 7) ? 8 - f : 1);
            if (f == 10) chk_ball("f10_bottom", 50, 22);
        end
        chk_ball("f11_bounce_bottom", 51, 21);
        down_0 = 1'b1;
        run_until(12);
        chk("p0y_both", 32'(p0), 1);
        up_0 = 1'b0; down_0 = 1'b0; up_1 = 1'b1;
        run_until(14);
        chk("p1y_up", 32'(p1), 5);
        up_1 = 1'b0;

        run_until(31); chk_ball("f31_top", 71, 1);
        run_until(32); chk_ball("f32_bounce_top", 72, 2);
        run_until(35); chk_ball("f35", 75, 5);
        run_until(36); chk_ball("f36_hit_right", 74, 6);
        run_until(106); chk_ball("f106", 4, 10);
        run_until(107); chk_ball("f107_hit_left", 5, 9);
        run_until(177); chk_ball("f177_miss_right", 75, 21);
        run_until(181); chk_ball("f181_serve", 40, 12);
        chk("f181_s0", 32'(s0), 1);
        chk("f181_s1", 32'(s1), 0);

        // Move the left paddle out of the way so every later ball misses on the left.
        run_until(199);
        down_0 = 1'b1;
        run_until(211);
        chk("p0y_down_limit", 32'(p0), 13);
        down_0 = 1'b0;
        run_until(217); chk_ball("f217_hit_right", 74, 6);
        run_until(290); chk_ball("f290", 1, 7);
        run_until(291); chk_ball("f291_serve", 40, 12);
        chk("f291_s1", 32'(s1), 1);
        run_until(301); chk_ball("f301", 30, 22);
        run_until(302); chk_ball("f302", 29, 21);
        run_until(571);
        chk("f571_s1", 32'(s1), 8);
        chk("f571_go", 32'(go), 0);
        run_until(611);
        chk("f611_s1", 32'(s1), 9);
        chk("f611_go", 32'(go), 1);
        chk_ball("f611", 40, 12);
        run_until(612);
        chk_ball("f612_frozen", 40, 12);
        chk("f612_s1", 32'(s1), 9);
        chk("f612_go", 32'(go), 1);
        up_1 = 1'b1;
        run_until(613);
        chk("f613_p1y", 32'(p1), 4);
        chk_ball("f613_frozen", 40, 12);
        up_1 = 1'b0;

        // Extended busy spanning several tick wraps, then exactly one paddle step.
        do_frame(12, lat);
        chk("f614_p0y", 32'(p0), 13);
        up_0 = 1'b1;
        do_frame(0, lat);
        chk("f615_p0y_one_step", 32'(p0), 12);
        up_0 = 1'b0;
        chk("stray_start", stray, 0);
        chk("moved_while_busy", moved, 0);

        // Reset while the mapper is rendering.
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(posedge clock); #1;
            if (start) got = 1'b1;
        end
        chk("f616_start_seen", 32'(got), 1);
        @(posedge clock); #1;
        busy = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_start", 32'(start), 0);
        chk("mid_rst_ball_x", 32'(ball_x), 40);
        chk("mid_rst_ball_y", 32'(ball_y), 12);
        chk("mid_rst_p0y", 32'(paddle_0_y), 7);
        chk("mid_rst_p1y", 32'(paddle_1_y), 7);
        chk("mid_rst_s0", 32'(score_0), 0);
        chk("mid_rst_s1", 32'(score_1), 0);
        chk("mid_rst_go", 32'(game_over), 0);
        busy = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        do_frame(0, lat);
        chk("rerun_latency", lat, 7);
        chk_ball("rerun_f1", 41, 13);
        chk("rerun_go", 32'(go), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
